// File: rtl/cbi980_axil_master.sv
// cbi980_axil_master: single-outstanding AXI4-Lite initiator driven by a valid/ready command port
// Ports:
//   aclk_i, arstn_i              clock, synchronous active-low reset
//   cmd_*                        command in (we/addr/wdata/wstrb), cmd_ready_o accepts
//   rsp_*                        response out (we echo, rdata, resp), rsp_ready_i consumes
//   aw*/w*/b*/ar*/r*             AXI4-Lite master channels
module cbi980_axil_master #(
   parameter logic [2:0] AXI_PROT  = 3'b000,
   parameter logic [3:0] AXI_CACHE = 4'b0000
) (
   input  logic        aclk_i,
   input  logic        arstn_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   input  logic [3:0]  cmd_wstrb_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_we_o,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  rsp_resp_o,
   output logic [31:0] awaddr_o,
   output logic [2:0]  awprot_o,
   output logic [3:0]  awcache_o,
   output logic        awvalid_o,
   input  logic        awready_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic        wvalid_o,
   input  logic        wready_i,
   input  logic [1:0]  bresp_i,
   input  logic        bvalid_i,
   output logic        bready_o,
   output logic [31:0] araddr_o,
   output logic [2:0]  arprot_o,
   output logic [3:0]  arcache_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        rvalid_i,
   output logic        rready_o
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  resp_q, resp_d;
   logic        we_q, we_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   always_ff @(posedge aclk_i) begin
      if (!arstn_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         we_q      <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         we_q      <= we_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      we_d      = we_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: if (cmd_valid_i) begin
            addr_d    = cmd_addr_i;
            wdata_d   = cmd_wdata_i;
            wstrb_d   = cmd_wstrb_i;
            we_d      = cmd_we_i;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = cmd_we_i ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            // the valid of a done channel is already low, so OR-ing the ready is safe
            aw_done_d = aw_done_q | awready_i;
            w_done_d  = w_done_q | wready_i;
            state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
         end
         WR_RESP: if (bvalid_i) begin
            resp_d  = bresp_i;
            rdata_d = '0;
            state_d = RSP;
         end
         RD_REQ: state_d = arready_i ? RD_DATA : RD_REQ;
         RD_DATA: if (rvalid_i) begin
            resp_d  = rresp_i;
            rdata_d = rdata_i;
            state_d = RSP;
         end
         RSP: state_d = rsp_ready_i ? IDLE : RSP;
         default: state_d = IDLE;
      endcase
   end
   assign cmd_ready_o = state_q == IDLE;
   assign rsp_valid_o = state_q == RSP;
   assign rsp_we_o    = we_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_resp_o  = resp_q;
   assign awaddr_o    = addr_q;
   assign awprot_o    = AXI_PROT;
   assign awcache_o   = AXI_CACHE;
   assign awvalid_o   = state_q == WR_REQ && !aw_done_q;
   assign wdata_o     = wdata_q;
   assign wstrb_o     = wstrb_q;
   assign wvalid_o    = state_q == WR_REQ && !w_done_q;
   assign bready_o    = state_q == WR_RESP;
   assign araddr_o    = addr_q;
   assign arprot_o    = AXI_PROT;
   assign arcache_o   = AXI_CACHE;
   assign arvalid_o   = state_q == RD_REQ;
   assign rready_o    = state_q == RD_DATA;
endmodule

// File: tb/tb_cbi980_axil_master.sv
// tb_cbi980_axil_master: directed vector bench for the AXI4-Lite initiator
module tb_cbi980_axil_master;
   logic        aclk_i = 1'b0, arstn_i = 1'b0;
   logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
   logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
   logic [3:0]  cmd_wstrb_i = '0;
   logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_we_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_resp_o;
   logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i = '0;
   logic [2:0]  awprot_o, arprot_o;
   logic [3:0]  awcache_o, arcache_o, wstrb_o;
   logic        awvalid_o, awready_i = 1'b0, wvalid_o, wready_i = 1'b0;
   logic [1:0]  bresp_i = '0, rresp_i = '0;
   logic        bvalid_i = 1'b0, bready_o, arvalid_o, arready_i = 1'b0, rvalid_i = 1'b0, rready_o;
   int          tests = 0, fails = 0;

   cbi980_axil_master dut (
      .aclk_i(aclk_i), .arstn_i(arstn_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
      .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awcache_o(awcache_o),
      .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
      .araddr_o(araddr_o), .arprot_o(arprot_o), .arcache_o(arcache_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
   );

   always #5 aclk_i = ~aclk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          ad, wd, bd, rd;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t vecs[7];

   task automatic step();
      @(posedge aclk_i);
      #1;
   endtask

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // ad/wd: cycles awready/wready (or arready) lag their valid; bd: bvalid/rvalid lag;
   // rd: cycles rsp_ready is held low
   task automatic run_txn(input vec_t v, input int id);
      string p;
      bit    af, wf, bf;
      int    c, bc;
      p = $sformatf("v%0d_", id);
      chk({p, "cmd_ready"}, cmd_ready_o, 1);
      cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_addr_i = v.addr;
      cmd_wdata_i = v.wdata; cmd_wstrb_i = v.wstrb;
      step();
      cmd_valid_i = 1'b0; cmd_we_i = ~v.we; cmd_addr_i = ~v.addr;
      cmd_wdata_i = ~v.wdata; cmd_wstrb_i = ~v.wstrb;
      c = 1; bc = 0; af = 0; wf = 0; bf = 0;
      if (v.we) begin
         while (!(af && wf)) begin
            chk({p, "awvalid"}, awvalid_o, !af);
            chk({p, "wvalid"}, wvalid_o, !wf);
            if (!af) chk({p, "aw_fields"}, {awaddr_o, awprot_o, awcache_o}, {v.addr, 7'd0});
            if (!wf) chk({p, "w_fields"}, {wdata_o, wstrb_o}, {v.wdata, v.wstrb});
            chk({p, "wreq_quiet"}, {arvalid_o, bready_o, rready_o, rsp_valid_o, cmd_ready_o}, 0);
            awready_i = c >= 1 + v.ad; wready_i = c >= 1 + v.wd;
            bvalid_i = 1'b1; bresp_i = 2'b11;
            step(); c++;
            if (awready_i) af = 1;
            if (wready_i) wf = 1;
         end
         awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
         while (!bf) begin
            chk({p, "wresp_state"}, {awvalid_o, wvalid_o, bready_o, rsp_valid_o}, 4'b0010);
            bvalid_i = bc >= v.bd; bresp_i = v.resp;
            step(); c++;
            bf = bvalid_i; bc++;
         end
      end else begin
         while (!af) begin
            chk({p, "rreq_state"}, {arvalid_o, awvalid_o, wvalid_o, bready_o, rready_o, rsp_valid_o, cmd_ready_o}, 7'b1000000);
            chk({p, "ar_fields"}, {araddr_o, arprot_o, arcache_o}, {v.addr, 7'd0});
            arready_i = c >= 1 + v.ad;
            rvalid_i = 1'b1; rdata_i = 32'hBAD0BAD0; rresp_i = 2'b11;
            step(); c++;
            if (arready_i) af = 1;
         end
         arready_i = 1'b0; rvalid_i = 1'b0;
         while (!bf) begin
            chk({p, "rdata_state"}, {arvalid_o, rready_o, rsp_valid_o}, 3'b010);
            rvalid_i = bc >= v.bd; rdata_i = v.rdata; rresp_i = v.resp;
            step(); c++;
            bf = rvalid_i; bc++;
         end
      end
      bvalid_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h5EED5EED; rresp_i = 2'b01;
      for (int k = 0; k <= v.rd; k++) begin
         chk({p, "rsp"}, {rsp_valid_o, rsp_we_o, rsp_resp_o, rsp_rdata_o}, {1'b1, v.we, v.exp_resp, v.exp_rdata});
         chk({p, "rsp_busy"}, {cmd_ready_o, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 0);
         rsp_ready_i = k >= v.rd;
         cmd_valid_i = k < v.rd;
         step();
      end
      rsp_ready_i = 1'b0; cmd_valid_i = 1'b0;
      chk({p, "rsp_done"}, rsp_valid_o, 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0, 2'b00};
      vecs[1] = '{1'b1, 32'h14, 32'h11223344, 4'h3, 32'h0, 2'b01, 0, 3, 0, 0, 32'h0, 2'b01};
      vecs[2] = '{1'b1, 32'h18, 32'hCAFEF00D, 4'hC, 32'h0, 2'b10, 3, 0, 1, 0, 32'h0, 2'b10};
      vecs[3] = '{1'b1, 32'h1C, 32'h0BADC0DE, 4'hF, 32'h0, 2'b00, 2, 2, 0, 0, 32'h0, 2'b00};
      vecs[4] = '{1'b0, 32'h04, 32'h0, 4'h0, 32'h12345678, 2'b10, 2, 0, 0, 0, 32'h12345678, 2'b10};
      vecs[5] = '{1'b0, 32'h08, 32'h0, 4'h0, 32'hA5A55A5A, 2'b00, 0, 0, 3, 5, 32'hA5A55A5A, 2'b00};
      vecs[6] = '{1'b1, 32'h24, 32'h0F0F0F0F, 4'h1, 32'h0, 2'b11, 1, 0, 2, 5, 32'h0, 2'b11};
      arstn_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         awready_i = 1'($urandom); wready_i = 1'($urandom); bvalid_i = 1'($urandom);
         arready_i = 1'($urandom); rvalid_i = 1'($urandom); bresp_i = 2'($urandom);
         rresp_i = 2'($urandom); rdata_i = $urandom;
         step();
         chk("rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
         chk("rst_rsp", {rsp_we_o, rsp_resp_o, rsp_rdata_o}, 0);
      end
      awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; arready_i = 1'b0; rvalid_i = 1'b0;
      arstn_i = 1'b1;
      step();
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_release_quiet", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
      for (int i = 0; i < 7; i++) run_txn(vecs[i], i);
      // abandon a write after only AW has fired
      step();
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h40; cmd_wdata_i = 32'h77; cmd_wstrb_i = 4'hF;
      step();
      cmd_valid_i = 1'b0;
      chk("mr_valids", {awvalid_o, wvalid_o}, 2'b11);
      awready_i = 1'b1;
      step();
      awready_i = 1'b0;
      chk("mr_aw_done", {awvalid_o, wvalid_o}, 2'b01);
      arstn_i = 1'b0;
      step();
      chk("mr_reset_quiet", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid_o}, 0);
      arstn_i = 1'b1;
      bvalid_i = 1'b1; bresp_i = 2'b10;
      step();
      chk("mr_no_rsp", {rsp_valid_o, cmd_ready_o, bready_o}, 3'b010);
      bvalid_i = 1'b0;
      step();
      chk("mr_still_idle", {rsp_valid_o, cmd_ready_o}, 2'b01);
      run_txn(vecs[0], 7);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cbi980_axil_master.md
# cbi980_axil_master

Single-outstanding AXI4-Lite initiator for the CBI980 I2S subsystem. It turns a simple valid/ready command port into AXI4-Lite read and write transactions towards the CBI980 register slave, and returns the response on a valid/ready response port. It is used by on-chip sequencers and by the system-level bench to program and poll the I2S controller. It drives AW and W independently and holds at most one transaction in flight.

## Interface
Parameters:
- AXI_PROT, 3'b000, value driven on awprot/arprot
- AXI_CACHE, 4'b0000, value driven on awcache/arcache

Ports:
- aclk  in  1  clock; all logic on rising edge
- arstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data (ignored for reads)
- cmd_wstrb  in  4  write strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_we  out  1  echo of cmd_we of the completed command
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  captured rresp or bresp
- awaddr/awprot/awcache/awvalid  out  32/3/4/1, awready in 1
- wdata/wstrb/wvalid  out  32/4/1, wready in 1
- bresp in 2, bvalid in 1, bready out 1
- araddr/arprot/arcache/arvalid  out  32/3/4/1, arready in 1
- rdata in 32, rresp in 2, rvalid in 1, rready out 1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid: latch addr/wdata/wstrb/we. If we=1, go to WR_REQ and clear the aw_done and w_done flags. If we=0, go to RD_REQ.
- WR_REQ: awvalid = ~aw_done and wvalid = ~w_done.
  - awvalid&awready sets aw_done. wvalid&wready sets w_done. These may occur in either order or in the same cycle.
  - Once both flags are set (counting handshakes in the current cycle), go to WR_RESP.
  - Valids never drop before their handshake. Address and data are stable while valid.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0 and go to RSP.
- RD_REQ: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp and go to RSP.
- RSP: rsp_valid=1. On rsp_ready, go to IDLE.
- bvalid/rvalid outside WR_RESP/RD_DATA are ignored (bready/rready low).
- awaddr/araddr = latched address. prot/cache fields are the parameter constants.
- rsp_resp is passed through unmodified, including SLVERR 2'b10; no retry.
- Exactly one transaction in flight; cmd_ready stays low from acceptance until the RSP handshake.

## Timing
- All outputs registered or decoded from the state register only; no combinational path from any input to any output.
- Reset (arstn=0 at an edge): state=IDLE. awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0. rsp_rdata, rsp_resp, rsp_we = 0. cmd_ready = 1 in the first cycle after release.
- Reset mid-transaction abandons it with no response. The system must reset the slave in the same cycle.
- Write, zero-wait slave: command accepted at edge 0; awvalid/wvalid high in cycle 1; both ready in cycle 1 moves to WR_RESP at edge 2. bvalid in cycle 2 gives rsp_valid in cycle 3. Total: 3 cycles from acceptance to rsp_valid.
- Read, zero-wait slave: arvalid in cycle 1, rready in cycle 2, rsp_valid in cycle 3.
- Back-to-back: with rsp_ready held high, the next command is accepted in the cycle after the RSP handshake. Peak rate is one transaction per 4 cycles.
- Slave ready/valid stalls extend the corresponding state indefinitely; there is no timeout.

## Test plan
- Reset: hold arstn=0 for 3 cycles with random AXI inputs -> all valids/readies low, rsp_* = 0, cmd_ready=1 after release.
- Write, zero-wait slave: cmd we=1, addr 0x10, data 0xDEADBEEF, wstrb 0xF -> AW/W seen in cycle 1 with those values, bready in cycle 2, rsp_valid cycle 3 with rsp_resp=00 and rsp_rdata=0.
- Write, skewed readies: awready 3 cycles before wready, then the reverse order, then both simultaneous -> each channel fires exactly once, the valid is held until its handshake, and there is exactly one response per command.
- Read with SLVERR: cmd we=0, addr 0x04; arready delayed 2 cycles, rvalid with rdata 0x12345678 and rresp 10 -> rsp_rdata=0x12345678, rsp_resp=10.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_valid/data stable, cmd_ready low, and a new cmd_valid is not accepted until the handshake.
- Reset asserted in WR_REQ after aw_done -> all AXI valids low next cycle, no rsp_valid, and a fresh write completes normally afterward.
